vec_gather_16: RTL and testbench

VEC_GATHER_16 -- requirements
Module: vec_gather_16

---
 rtl/vec_gather_16.sv | 119 +++++++++++
 tb/tb_vec_gather_16.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_gather_16.sv
// vec_gather_16
// Gathers a stream of 64-bit beats (four FP16 lanes each) into 16-element
// vectors for a downstream 16-to-1 adder tree. A vector ends after four beats
// or on an earlier beat flagged in_last. Elements the stream did not supply
// are filled with PAD_VAL.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat this cycle (depends on registered state only)
//   in_data    four FP16 lanes, lane j at [16j+15:16j]
//   in_last    final beat of the current vector (qualified by in_valid)
//   out_valid  out_vec holds a complete vector
//   out_ready  downstream accepts the vector
//   out_vec    16 FP16 elements, element i at [16i+15:16i]
//   out_count  stream-supplied elements in out_vec: 4, 8, 12 or 16
//
// Handshake: a beat moves on a rising edge where in_valid & in_ready are both
// high; a vector moves on a rising edge where out_valid & out_ready are both
// high. A producer holding valid high keeps its payload stable until it moves;
// ready never depends combinationally on valid.
//
// Storage is two slots: a fill buffer that assembles the current vector and
// the output register. A finished vector that cannot enter the output register
// stays parked in the fill buffer (held) and blocks further input until it can.

module vec_gather_16 #(
  parameter logic [15:0] PAD_VAL = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_vec,
  output logic [4:0]   out_count
);

  logic [255:0] fill_buf;
  logic [255:0] asm_vec;
  logic [255:0] pad_vec;
  logic [1:0]   b;
  logic         held;
  logic [4:0]   held_cnt;

  logic         beat_acc;
  logic         complete;
  logic         out_free;
  logic [4:0]   new_cnt;

  assign pad_vec  = {16{PAD_VAL}};
  assign in_ready = !held;
  assign beat_acc = in_valid && in_ready;
  // in_last on the fourth beat changes nothing: the vector ends either way.
  assign complete = beat_acc && ((b == 2'd3) || in_last);
  // The output slot can take a vector if it is empty or is being drained now.
  assign out_free = !out_valid || out_ready;
  assign new_cnt  = {1'b0, b, 2'b00} + 5'd4;

  // Fill buffer with the incoming beat merged into elements 4b..4b+3.
  // Unwritten elements already hold PAD_VAL, so a short vector is padded
  // for free.
  always_comb begin
    asm_vec = fill_buf;
    for (int j = 0; j < 4; j++) begin
      asm_vec[{b, j[1:0], 4'b0000} +: 16] = in_data[j*16 +: 16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_count <= '0;
      fill_buf  <= {16{PAD_VAL}};
      b         <= 2'd0;
      held      <= 1'b0;
      held_cnt  <= 5'd0;
    end else begin
      // Drained vector leaves unless a new one loads at this same edge below.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (held) begin
        if (out_free) begin
          out_vec   <= fill_buf;
          out_count <= held_cnt;
          out_valid <= 1'b1;
          fill_buf  <= pad_vec;
          b         <= 2'd0;
          held      <= 1'b0;
        end
      end else if (beat_acc) begin
        if (complete) begin
          if (out_free) begin
            out_vec   <= asm_vec;
            out_count <= new_cnt;
            out_valid <= 1'b1;
            fill_buf  <= pad_vec;
            b         <= 2'd0;
          end else begin
            fill_buf  <= asm_vec;
            held      <= 1'b1;
            held_cnt  <= new_cnt;
          end
        end else begin
          fill_buf <= asm_vec;
          b        <= b + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_gather_16.sv
// tb_vec_gather_16
// Self-checking bench for vec_gather_16. A reference model collects accepted
// lanes in a queue and cuts a vector at 16 lanes or on in_last, padding the
// rest; observed vectors are compared against it in order.

module tb_vec_gather_16;

  localparam logic [15:0] PAD = 16'h0000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_vec;
  logic [4:0]   out_count;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int cyc    = 0;
  int stall_viol = 0;

  logic         prev_stall;
  logic [255:0] prev_vec;
  logic [4:0]   prev_cnt;

  logic [15:0]  lanes_q[$];
  logic [255:0] exp_vec_q[$];
  logic [4:0]   exp_cnt_q[$];
  logic [255:0] got_vec_q[$];
  logic [4:0]   got_cnt_q[$];
  int           fire_cyc_q[$];

  vec_gather_16 #(.PAD_VAL(PAD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_count (out_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_beat(input logic [63:0] d, input logic l);
    logic [255:0] v;
    for (int j = 0; j < 4; j++) lanes_q.push_back(d[j*16 +: 16]);
    if (lanes_q.size() == 16 || l) begin
      for (int i = 0; i < 16; i++)
        v[i*16 +: 16] = (i < lanes_q.size()) ? lanes_q[i] : PAD;
      exp_vec_q.push_back(v);
      exp_cnt_q.push_back(5'(lanes_q.size()));
      lanes_q.delete();
    end
  endtask

  task automatic clear_sb();
    exp_vec_q.delete();
    exp_cnt_q.delete();
    got_vec_q.delete();
    got_cnt_q.delete();
    fire_cyc_q.delete();
    beats = 0;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: sample handshakes at the falling edge, then return 1 time
  // unit after the next rising edge, where inputs are driven.
  task automatic tick();
    @(negedge clk);
    if (prev_stall) begin
      if (out_valid !== 1'b1 || out_vec !== prev_vec || out_count !== prev_cnt)
        stall_viol++;
    end
    if (in_valid && in_ready) begin
      model_beat(in_data, in_last);
      beats++;
    end
    if (out_valid && out_ready) begin
      got_vec_q.push_back(out_vec);
      got_cnt_q.push_back(out_count);
      fire_cyc_q.push_back(cyc);
    end
    prev_stall = out_valid && !out_ready;
    prev_vec   = out_vec;
    prev_cnt   = out_count;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lanes_q.delete();
    clear_sb();
    prev_stall = 1'b0;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_vec !== 256'd0) begin errors++; $display("FAIL reset_out_vec: got %h exp 0", out_vec); end
    checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL reset_out_count: got %0d exp 0", out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_full_vector();
    logic [255:0] ev;
    clear_sb();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) ev[i*16 +: 16] = 16'(i + 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b exp 1", out_valid); end
    checks++; if (out_vec !== ev) begin errors++; $display("FAIL full_vec: got %h exp %h", out_vec, ev); end
    checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d exp 16", out_count); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_fall: got %b exp 0", out_valid); end
  endtask

  task automatic test_short_vector();
    logic [255:0] ev;
    clear_sb();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = 64'h3C00_3C00_3C00_3C00;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 16; i++) ev[i*16 +: 16] = (i < 4) ? 16'h3C00 : 16'h0000;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL short_valid: got %b exp 1", out_valid); end
    checks++; if (out_vec !== ev) begin errors++; $display("FAIL short_vec: got %h exp %h", out_vec, ev); end
    checks++; if (out_count !== 5'd4) begin errors++; $display("FAIL short_count: got %0d exp 4", out_count); end
    tick();
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_sb();
    out_ready = 1'b0;
    while (beats < 8 && n < 20) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = rand64();
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++; if (beats != 8) begin errors++; $display("FAIL bp_beats: got %0d exp 8", beats); end
    if (exp_vec_q.size() < 2) begin
      errors++; $display("FAIL bp_model: got %0d vectors exp 2", exp_vec_q.size());
      return;
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b exp 1", out_valid); end
    checks++; if (out_vec !== exp_vec_q[0]) begin errors++; $display("FAIL bp_first_vec: got %h exp %h", out_vec, exp_vec_q[0]); end
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold: got %b exp 0", in_ready); end
    checks++; if (out_vec !== exp_vec_q[0]) begin errors++; $display("FAIL bp_first_hold: got %h exp %h", out_vec, exp_vec_q[0]); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b exp 1", out_valid); end
    checks++; if (out_vec !== exp_vec_q[1]) begin errors++; $display("FAIL bp_second_vec: got %h exp %h", out_vec, exp_vec_q[1]); end
    checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL bp_second_count: got %0d exp 16", out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b exp 1", in_ready); end
    tick();
    checks++; if (got_vec_q.size() != 2) begin errors++; $display("FAIL bp_got_count: got %0d exp 2", got_vec_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_vec_q[i] !== exp_vec_q[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h exp %h", i, got_vec_q[i], exp_vec_q[i]); end
      end
    end
  endtask

  task automatic test_throughput();
    int low = 0;
    int bad_gap = 0;
    clear_sb();
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = rand64();
      if (in_ready !== 1'b1) low++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (low != 0) begin errors++; $display("FAIL tp_in_ready_low: got %0d low cycles exp 0", low); end
    checks++; if (beats != 40) begin errors++; $display("FAIL tp_beats: got %0d exp 40", beats); end
    checks++; if (got_vec_q.size() != 10) begin errors++; $display("FAIL tp_vectors: got %0d exp 10", got_vec_q.size()); end
    for (int i = 1; i < fire_cyc_q.size(); i++)
      if (fire_cyc_q[i] - fire_cyc_q[i-1] != 4) bad_gap++;
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL tp_spacing: got %0d bad gaps exp 0", bad_gap); end
    for (int i = 0; i < got_vec_q.size() && i < exp_vec_q.size(); i++) begin
      checks++;
      if (got_vec_q[i] !== exp_vec_q[i] || got_cnt_q[i] !== exp_cnt_q[i]) begin
        errors++; $display("FAIL tp_vec[%0d]: got %h/%0d exp %h/%0d", i, got_vec_q[i], got_cnt_q[i], exp_vec_q[i], exp_cnt_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = rand64();
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_async: got %b exp 0", out_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lanes_q.delete();
    clear_sb();
    prev_stall = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b exp 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = rand64();
      tick();
    end
    in_valid = 1'b0;
    if (exp_vec_q.size() != 1) begin
      errors++; $display("FAIL rmid_model: got %0d vectors exp 1", exp_vec_q.size());
      return;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid: got %b exp 1", out_valid); end
    checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL rmid_count: got %0d exp 16", out_count); end
    checks++; if (out_vec !== exp_vec_q[0]) begin errors++; $display("FAIL rmid_vec: got %h exp %h", out_vec, exp_vec_q[0]); end
    tick();
  endtask

  task automatic test_random();
    int n;
    int b0;
    clear_sb();
    stall_viol = 0;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) > 1);
      in_last   = ($urandom_range(0, 4) == 0);
      in_data   = rand64();
      tick();
    end
    // Close any partial vector with a final in_last beat.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = rand64();
    b0 = beats;
    n  = 0;
    while (beats == b0 && n < 50) begin tick(); n++; end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n = 0;
    while (got_vec_q.size() < exp_vec_q.size() && n < 50) begin tick(); n++; end
    tick();
    checks++; if (got_vec_q.size() != exp_vec_q.size()) begin errors++; $display("FAIL rand_vec_total: got %0d exp %0d", got_vec_q.size(), exp_vec_q.size()); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stall_stable: got %0d changes exp 0", stall_viol); end
    checks++; if (exp_vec_q.size() < 20) begin errors++; $display("FAIL rand_activity: got %0d vectors exp >= 20", exp_vec_q.size()); end
    for (int i = 0; i < got_vec_q.size() && i < exp_vec_q.size(); i++) begin
      checks++;
      if (got_vec_q[i] !== exp_vec_q[i] || got_cnt_q[i] !== exp_cnt_q[i]) begin
        errors++; $display("FAIL rand_vec[%0d]: got %h/%0d exp %h/%0d", i, got_vec_q[i], got_cnt_q[i], exp_vec_q[i], exp_cnt_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    prev_stall = 1'b0;
    prev_vec   = '0;
    prev_cnt   = '0;
    test_reset();
    test_full_vector();
    test_short_vector();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
